// File: rtl/ope_fetch_if.sv
// Memory read port, redirect input and instruction presentation port of the fetcher.
// The master modport is the fetcher; the slave modport is memory plus execute side.
interface ope_fetch_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        eip_load;
  logic [31:0] eip_new;
  logic [31:0] ope;
  logic [3:0]  num_of_ope;
  logic [31:0] ope_eip;
  logic        ope_valid;
  logic        ope_ready;
  logic        illegal;

  modport master (
    output mem_addr, mem_rd, ope, num_of_ope, ope_eip, ope_valid, illegal,
    input  mem_data, mem_ack, eip_load, eip_new, ope_ready
  );

  modport slave (
    input  mem_addr, mem_rd, ope, num_of_ope, ope_eip, ope_valid, illegal,
    output mem_data, mem_ack, eip_load, eip_new, ope_ready
  );
endinterface

// File: rtl/ope_fetch.sv
// Byte-serial instruction fetcher and length decoder: packs up to four bytes of one
// instruction left-justified into ope and holds them until the execute side accepts.
module ope_fetch #(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  ope_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH0, FETCHN, HOLD, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] eip_q, eip_d;
  logic [31:0] flush_addr_q, flush_addr_d;
  logic [31:0] ope_q, ope_d;
  logic [31:0] ope_eip_q, ope_eip_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  len_q, len_d;
  logic        illegal_q, illegal_d;
  logic        rd_en_q;

  logic [31:0] cur_addr;
  logic        take;
  logic [4:0]  dec0;
  logic [3:0]  len_n;

  // Returns {illegal, length}. 0x83 reports 3 here and is refined once byte1 is seen.
  function automatic logic [4:0] decode_len(input logic [7:0] b);
    unique case (b)
      8'h55, 8'h50, 8'h53, 8'h5d, 8'hc3, 8'hc9: decode_len = {1'b0, 4'd1};
      8'h89, 8'h6a, 8'h75, 8'heb, 8'h01:        decode_len = {1'b0, 4'd2};
      8'h8b, 8'h83:                             decode_len = {1'b0, 4'd3};
      8'hb8, 8'he8:                             decode_len = {1'b0, 4'd5};
      default:                                  decode_len = {1'b1, 4'd1};
    endcase
  endfunction

  always_comb begin
    cur_addr          = eip_q + {29'd0, cnt_q};
    bus.mem_rd        = rd_en_q && (state_q != HOLD);
    bus.mem_addr      = (state_q == FLUSH) ? flush_addr_q : cur_addr;
    bus.ope           = ope_q;
    bus.num_of_ope    = len_q;
    bus.ope_eip       = ope_eip_q;
    bus.ope_valid     = (state_q == HOLD);
    bus.illegal       = illegal_q;
    take              = bus.mem_rd && bus.mem_ack;
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    eip_d        = eip_q;
    flush_addr_d = flush_addr_q;
    ope_d        = ope_q;
    ope_eip_d    = ope_eip_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    illegal_d    = illegal_q;
    dec0         = decode_len(bus.mem_data);
    len_n        = len_q;

    unique case (state_q)
      FETCH0: begin
        if (take) begin
          ope_d     = {bus.mem_data, 24'd0};
          ope_eip_d = eip_q;
          illegal_d = dec0[4];
          len_d     = dec0[3:0];
          cnt_d     = 3'd1;
          state_d   = (dec0[3:0] == 4'd1) ? HOLD : FETCHN;
        end
      end
      FETCHN: begin
        if (take) begin
          if (cnt_q == 3'd1 && ope_q[31:24] == 8'h83)
            len_n = (bus.mem_data == 8'h7d) ? 4'd4 : 4'd3;
          len_d = len_n;
          // Byte 4 of a 5-byte instruction is consumed but not stored.
          unique case (cnt_q)
            3'd1:    ope_d[23:16] = bus.mem_data;
            3'd2:    ope_d[15:8]  = bus.mem_data;
            3'd3:    ope_d[7:0]   = bus.mem_data;
            default: ope_d        = ope_q;
          endcase
          cnt_d = cnt_q + 3'd1;
          if ({1'b0, cnt_q} + 4'd1 == len_n) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.ope_ready) begin
          eip_d     = eip_q + {28'd0, len_q};
          state_d   = FETCH0;
          cnt_d     = 3'd0;
          ope_d     = 32'd0;
          len_d     = 4'd0;
          illegal_d = 1'b0;
        end
      end
      FLUSH: begin
        if (take) state_d = FETCH0;
      end
      default: state_d = FETCH0;
    endcase

    // A redirect wins over accept and over any byte captured this cycle.
    if (bus.eip_load) begin
      eip_d     = bus.eip_new;
      cnt_d     = 3'd0;
      ope_d     = 32'd0;
      len_d     = 4'd0;
      illegal_d = 1'b0;
      if (state_q == FLUSH) begin
        state_d = take ? FETCH0 : FLUSH;
      end else if (bus.mem_rd && !bus.mem_ack) begin
        state_d      = FLUSH;
        flush_addr_d = cur_addr;
      end else begin
        state_d = FETCH0;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (reset) begin
      state_q      <= FETCH0;
      eip_q        <= RESET_EIP;
      flush_addr_q <= 32'd0;
      ope_q        <= 32'd0;
      ope_eip_q    <= 32'd0;
      cnt_q        <= 3'd0;
      len_q        <= 4'd0;
      illegal_q    <= 1'b0;
      rd_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      eip_q        <= eip_d;
      flush_addr_q <= flush_addr_d;
      ope_q        <= ope_d;
      ope_eip_q    <= ope_eip_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      illegal_q    <= illegal_d;
      rd_en_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ope_fetch.sv
// Directed bench for ope_fetch: a table of instructions fetched back to back,
// then hand-written sequences for wait states, redirects, address wrap and reset.
module tb_ope_fetch;

  logic clock = 1'b0;
  logic reset;
  logic ack_block;
  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;

  ope_fetch_if bus ();

  ope_fetch #(.RESET_EIP(32'h0000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always_comb begin
    bus.mem_ack  = bus.mem_rd && !ack_block;
    bus.mem_data = mem[bus.mem_addr[7:0]];
  end

  typedef struct {
    logic [39:0] raw;
    logic [3:0]  num;
    logic [31:0] ope;
    logic        ill;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (bus.ope_valid !== 1'b1 && n < max) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.ope_valid !== 1'b1) begin
      failures++;
      $display("FAIL valid_timeout: got ope_valid=%b expected 1 within %0d cycles", bus.ope_valid, max);
    end
  endtask

  task automatic accept();
    bus.ope_ready = 1'b1;
    @(negedge clock);
    bus.ope_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.eip_load = 1'b1;
    bus.eip_new  = target;
    @(negedge clock);
    bus.eip_load = 1'b0;
  endtask

  initial begin
    int n;
    int addr;
    logic [31:0] exp_eip;

    vecs[0]  = '{40'h55_0000_0000, 4'd1, 32'h5500_0000, 1'b0};
    vecs[1]  = '{40'h83_7df8_0000, 4'd4, 32'h837d_f800, 1'b0};
    vecs[2]  = '{40'h83_ec10_0000, 4'd3, 32'h83ec_1000, 1'b0};
    vecs[3]  = '{40'h8b_45fc_0000, 4'd3, 32'h8b45_fc00, 1'b0};
    vecs[4]  = '{40'h89_e500_0000, 4'd2, 32'h89e5_0000, 1'b0};
    vecs[5]  = '{40'h6a_0000_0000, 4'd2, 32'h6a00_0000, 1'b0};
    vecs[6]  = '{40'hb8_0102_0304, 4'd5, 32'hb801_0203, 1'b0};
    vecs[7]  = '{40'hc3_0000_0000, 4'd1, 32'hc300_0000, 1'b0};
    vecs[8]  = '{40'h90_0000_0000, 4'd1, 32'h9000_0000, 1'b1};
    vecs[9]  = '{40'h75_fe00_0000, 4'd2, 32'h75fe_0000, 1'b0};
    vecs[10] = '{40'heb_1000_0000, 4'd2, 32'heb10_0000, 1'b0};
    vecs[11] = '{40'h01_c800_0000, 4'd2, 32'h01c8_0000, 1'b0};
    vecs[12] = '{40'he8_eeff_ffff, 4'd5, 32'he8ee_ffff, 1'b0};
    vecs[13] = '{40'h5d_0000_0000, 4'd1, 32'h5d00_0000, 1'b0};
    vecs[14] = '{40'h50_0000_0000, 4'd1, 32'h5000_0000, 1'b0};
    vecs[15] = '{40'h53_0000_0000, 4'd1, 32'h5300_0000, 1'b0};
    vecs[16] = '{40'hc9_0000_0000, 4'd1, 32'hc900_0000, 1'b0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    addr = 0;
    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < int'(vecs[i].num); j++) mem[addr + j] = vecs[i].raw[39 - 8*j -: 8];
      addr += int'(vecs[i].num);
    end
    mem[100] = 8'h8b; mem[101] = 8'h45; mem[102] = 8'hfc;
    mem[103] = 8'hc3; mem[104] = 8'hc3;
    mem[40]  = 8'h6a; mem[41]  = 8'h05;
    mem[200] = 8'hc3; mem[201] = 8'h55;
    mem[80]  = 8'h53;
    mem[255] = 8'heb;

    reset = 1'b1;
    ack_block = 1'b0;
    bus.eip_load = 1'b0;
    bus.eip_new = 32'd0;
    bus.ope_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, bus.ope_valid}, 32'd0);
    check("rst_ope", bus.ope, 32'd0);
    check("rst_num", {28'd0, bus.num_of_ope}, 32'd0);
    check("rst_ope_eip", bus.ope_eip, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    reset = 1'b0;
    check("rd_after_rst", {31'd0, bus.mem_rd}, 32'd0);

    // Back-to-back instruction stream from address 0.
    exp_eip = 32'd0;
    for (int i = 0; i < 17; i++) begin
      wait_valid(20, n);
      check($sformatf("v%0d_latency", i), n, (i == 0) ? 32'd2 : {28'd0, vecs[i].num});
      check($sformatf("v%0d_ope", i), bus.ope, vecs[i].ope);
      check($sformatf("v%0d_num", i), {28'd0, bus.num_of_ope}, {28'd0, vecs[i].num});
      check($sformatf("v%0d_ope_eip", i), bus.ope_eip, exp_eip);
      check($sformatf("v%0d_illegal", i), {31'd0, bus.illegal}, {31'd0, vecs[i].ill});
      exp_eip += {28'd0, vecs[i].num};
      if (i < 16) begin
        accept();
        check($sformatf("v%0d_next_addr", i), bus.mem_addr, exp_eip);
        check($sformatf("v%0d_valid_drop", i), {31'd0, bus.ope_valid}, 32'd0);
      end
    end

    // Wait states on byte1 of 8b 45 fc at 100.
    redirect(32'd100);
    check("ws_addr0", bus.mem_addr, 32'd100);
    check("ws_valid0", {31'd0, bus.ope_valid}, 32'd0);
    @(negedge clock);
    ack_block = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("ws_addr_hold%0d", k), bus.mem_addr, 32'd101);
      check($sformatf("ws_rd_hold%0d", k), {31'd0, bus.mem_rd}, 32'd1);
    end
    ack_block = 1'b0;
    wait_valid(20, n);
    check("ws_ope", bus.ope, 32'h8b45_fc00);
    check("ws_num", {28'd0, bus.num_of_ope}, 32'd3);
    check("ws_ope_eip", bus.ope_eip, 32'd100);

    // Redirect while a read at 103 is outstanding: FLUSH, data dropped, restart at 40.
    ack_block = 1'b1;
    accept();
    check("fl_addr_pre", bus.mem_addr, 32'd103);
    redirect(32'd40);
    check("fl_addr_hold", bus.mem_addr, 32'd103);
    check("fl_rd_hold", {31'd0, bus.mem_rd}, 32'd1);
    @(negedge clock);
    check("fl_addr_hold2", bus.mem_addr, 32'd103);
    check("fl_valid", {31'd0, bus.ope_valid}, 32'd0);
    ack_block = 1'b0;
    @(negedge clock);
    check("fl_restart_addr", bus.mem_addr, 32'd40);
    check("fl_restart_valid", {31'd0, bus.ope_valid}, 32'd0);
    wait_valid(20, n);
    check("fl_ope", bus.ope, 32'h6a05_0000);
    check("fl_ope_eip", bus.ope_eip, 32'd40);

    // Redirect and accept in the same cycle: redirect wins.
    bus.ope_ready = 1'b1;
    redirect(32'd200);
    bus.ope_ready = 1'b0;
    check("ra_addr", bus.mem_addr, 32'd200);
    check("ra_valid", {31'd0, bus.ope_valid}, 32'd0);
    wait_valid(20, n);
    check("ra_ope", bus.ope, 32'hc300_0000);
    check("ra_ope_eip", bus.ope_eip, 32'd200);

    // Second redirect while already in FLUSH retargets.
    ack_block = 1'b1;
    accept();
    bus.eip_load = 1'b1;
    bus.eip_new  = 32'd60;
    @(negedge clock);
    bus.eip_new  = 32'd80;
    @(negedge clock);
    bus.eip_load = 1'b0;
    check("ff_addr_hold", bus.mem_addr, 32'd201);
    check("ff_rd_hold", {31'd0, bus.mem_rd}, 32'd1);
    ack_block = 1'b0;
    @(negedge clock);
    check("ff_restart_addr", bus.mem_addr, 32'd80);
    wait_valid(20, n);
    check("ff_ope", bus.ope, 32'h5300_0000);
    check("ff_ope_eip", bus.ope_eip, 32'd80);

    // Instruction straddling the top of the address space.
    redirect(32'hFFFF_FFFF);
    wait_valid(20, n);
    check("wr_ope", bus.ope, 32'heb55_0000);
    check("wr_num", {28'd0, bus.num_of_ope}, 32'd2);
    check("wr_ope_eip", bus.ope_eip, 32'hFFFF_FFFF);
    accept();
    check("wr_next_addr", bus.mem_addr, 32'd1);

    // Reset in the middle of a multi-byte fetch.
    @(negedge clock);
    check("mr_addr_pre", bus.mem_addr, 32'd2);
    reset = 1'b1;
    @(negedge clock);
    check("mr_valid", {31'd0, bus.ope_valid}, 32'd0);
    check("mr_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("mr_addr", bus.mem_addr, 32'd0);
    check("mr_ope", bus.ope, 32'd0);
    check("mr_num", {28'd0, bus.num_of_ope}, 32'd0);
    reset = 1'b0;
    wait_valid(20, n);
    check("mr_refetch_ope", bus.ope, 32'h5500_0000);
    check("mr_refetch_eip", bus.ope_eip, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
